// File: rtl/byte_word_packer_pkg.sv
// Shared stream geometry for the byte packer and the accelerator-side unpacker.
// Lane 0 carries the first byte of a word; lane_lo() is the single place that encodes that order.
package byte_word_packer_pkg;

    localparam int BYTE_W   = 8;
    localparam int LANES    = 9;
    localparam int STREAM_W = BYTE_W * LANES;
    localparam int IDX_W    = $clog2(LANES);

    localparam bit LANE_LSB_FIRST = 1'b1;

    function automatic int lane_lo(input int lane);
        return LANE_LSB_FIRST ? lane * BYTE_W : (LANES - 1 - lane) * BYTE_W;
    endfunction

endpackage

// File: rtl/byte_lane_merge.sv
// Combinational lane merge: drops the new byte into lane i_idx of the accumulator.
// With i_pad set, every lane above i_idx is forced to zero so a short word leaves clean.
module byte_lane_merge
    import byte_word_packer_pkg::*;
(
    input  logic [STREAM_W-1:0] i_acc,
    input  logic [IDX_W-1:0]    i_idx,
    input  logic [BYTE_W-1:0]   i_byte,
    input  logic                i_pad,
    output logic [STREAM_W-1:0] o_word
);

    always_comb begin
        o_word = '0;
        for (int l = 0; l < LANES; l++) begin
            if (IDX_W'(l) == i_idx) begin
                o_word[lane_lo(l) +: BYTE_W] = i_byte;
            end else if ((IDX_W'(l) < i_idx) || !i_pad) begin
                o_word[lane_lo(l) +: BYTE_W] = i_acc[lane_lo(l) +: BYTE_W];
            end
        end
    end

endmodule

// File: rtl/byte_word_packer.sv
// Packs 9 bytes into a 72-bit word, one cycle after the final byte; ss_last flushes a zero-padded word.
// Single output register; input stalls only while that register is full and not being drained.
module byte_word_packer
    import byte_word_packer_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [BYTE_W-1:0]   ss_data,
    input  logic                ss_valid,
    output logic                ss_ready,
    input  logic                ss_last,
    output logic [STREAM_W-1:0] ms_data,
    output logic                ms_valid,
    input  logic                ms_ready,
    output logic [CNT_W-1:0]    word_count,
    output logic [CNT_W-1:0]    pad_count
);

    logic [STREAM_W-1:0] r_acc;
    logic [IDX_W-1:0]    r_idx;
    logic [STREAM_W-1:0] r_ms_data;
    logic                r_ms_valid;
    logic [CNT_W-1:0]    r_word_count;
    logic [CNT_W-1:0]    r_pad_count;

    logic                w_accept;
    logic                w_last_lane;
    logic                w_complete;
    logic                w_drain;
    logic [STREAM_W-1:0] w_merged;

    // Ready depends only on registered state and ms_ready, never on ss_valid.
    assign ss_ready    = !reset && (!r_ms_valid || ms_ready);
    assign w_accept    = ss_valid && ss_ready;
    assign w_last_lane = (r_idx == IDX_W'(LANES - 1));
    assign w_complete  = w_accept && (w_last_lane || ss_last);
    assign w_drain     = r_ms_valid && ms_ready;

    byte_lane_merge u_merge (
        .i_acc  (r_acc),
        .i_idx  (r_idx),
        .i_byte (ss_data),
        .i_pad  (w_complete),
        .o_word (w_merged)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_acc        <= '0;
            r_idx        <= '0;
            r_ms_data    <= '0;
            r_ms_valid   <= 1'b0;
            r_word_count <= '0;
            r_pad_count  <= '0;
        end else begin
            if (w_accept) begin
                if (w_complete) begin
                    r_acc     <= '0;
                    r_idx     <= '0;
                    r_ms_data <= w_merged;
                end else begin
                    r_acc <= w_merged;
                    r_idx <= r_idx + 1'b1;
                end
            end

            // A load on the same edge as a drain keeps the register full.
            if (w_complete) begin
                r_ms_valid <= 1'b1;
            end else if (w_drain) begin
                r_ms_valid <= 1'b0;
            end

            if (w_drain) begin
                r_word_count <= r_word_count + 1'b1;
            end
            if (w_complete && !w_last_lane) begin
                r_pad_count <= r_pad_count + 1'b1;
            end
        end
    end

    assign ms_data    = r_ms_data;
    assign ms_valid   = r_ms_valid;
    assign word_count = r_word_count;
    assign pad_count  = r_pad_count;

endmodule

// File: tb/tb_byte_word_packer.sv
// Directed and random stimulus for byte_word_packer against a cycle model and word scoreboard.
module tb_byte_word_packer;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  ss_data;
    logic        ss_valid;
    logic        ss_ready;
    logic        ss_last;
    logic [71:0] ms_data;
    logic        ms_valid;
    logic        ms_ready;
    logic [31:0] word_count;
    logic [31:0] pad_count;

    always #5 clk = ~clk;

    byte_word_packer #(.CNT_W(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .ss_data    (ss_data),
        .ss_valid   (ss_valid),
        .ss_ready   (ss_ready),
        .ss_last    (ss_last),
        .ms_data    (ms_data),
        .ms_valid   (ms_valid),
        .ms_ready   (ms_ready),
        .word_count (word_count),
        .pad_count  (pad_count)
    );

    int          tests = 0;
    int          fails = 0;
    logic [71:0] sb_q[$];
    logic [71:0] m_acc;
    int          m_idx;
    bit          m_vld;
    logic [31:0] m_words;
    logic [31:0] m_pads;
    bit          last_acc;

    task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: check against the model mid-cycle, then advance the model to the next edge.
    task automatic tick();
        logic        exp_rdy;
        logic [71:0] w;
        @(negedge clk);
        exp_rdy = !reset && (!m_vld || ms_ready);
        check("ss_ready", 72'(ss_ready), 72'(exp_rdy));
        check("ms_valid", 72'(ms_valid), 72'(m_vld));
        last_acc = exp_rdy && ss_valid;
        if (reset) begin
            sb_q.delete();
            m_vld   = 1'b0;
            m_acc   = '0;
            m_idx   = 0;
            m_words = '0;
            m_pads  = '0;
        end else begin
            if (m_vld && ms_ready) begin
                check("sb_nonempty", 72'(sb_q.size() != 0), 72'(1));
                if (sb_q.size() != 0) begin
                    w = sb_q.pop_front();
                    check("ms_data", ms_data, w);
                end
                m_words++;
                m_vld = 1'b0;
            end
            if (last_acc) begin
                m_acc[m_idx*8 +: 8] = ss_data;
                if (m_idx == 8 || ss_last) begin
                    sb_q.push_back(m_acc);
                    if (m_idx < 8) m_pads++;
                    m_vld = 1'b1;
                    m_acc = '0;
                    m_idx = 0;
                end else begin
                    m_idx++;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] d, input bit l, input bit rnd, output int cyc);
        ss_data = d;
        ss_last = l;
        cyc = 0;
        do begin
            if (rnd) begin
                ss_valid = 1'($urandom_range(0, 1));
                ms_ready = 1'($urandom_range(0, 1));
            end else begin
                ss_valid = 1'b1;
            end
            tick();
            cyc++;
        end while (!last_acc && cyc < 200);
        check("send_timeout", 72'(last_acc), 72'(1));
    endtask

    task automatic idle(input int n);
        ss_valid = 1'b0;
        ss_last  = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          cyc;
        logic [71:0] d0;
        logic [31:0] w0;

        reset = 1'b1; ss_valid = 1'b0; ss_last = 1'b0; ss_data = 8'h00; ms_ready = 1'b0;
        m_acc = '0; m_idx = 0; m_vld = 1'b0; m_words = '0; m_pads = '0;
        tick(); tick(); tick();
        check("rst_ms_valid", 72'(ms_valid), 72'(0));
        check("rst_ms_data", ms_data, 72'h0);
        check("rst_ss_ready", 72'(ss_ready), 72'(0));
        check("rst_word_count", 72'(word_count), 72'(0));
        check("rst_pad_count", 72'(pad_count), 72'(0));
        reset = 1'b0;

        // Basic pack
        ms_ready = 1'b1;
        for (int b = 1; b <= 9; b++) send(8'(b), 1'b0, 1'b0, cyc);
        ss_valid = 1'b0;
        check("basic_valid", 72'(ms_valid), 72'(1));
        check("basic_data", ms_data, 72'h090807060504030201);
        tick();
        check("basic_word_count", 72'(word_count), 72'(1));
        check("basic_pad_count", 72'(pad_count), 72'(0));

        // Padding, then a single-byte packet landing in lane 0
        send(8'hA1, 1'b0, 1'b0, cyc);
        send(8'hA2, 1'b0, 1'b0, cyc);
        send(8'hA3, 1'b1, 1'b0, cyc);
        ss_valid = 1'b0;
        check("pad_data", ms_data, 72'h000000000000A3A2A1);
        check("pad_count_1", 72'(pad_count), 72'(1));
        tick();
        send(8'h5A, 1'b1, 1'b0, cyc);
        ss_valid = 1'b0;
        check("pad_lane0_data", ms_data, 72'h00000000000000005A);
        check("pad_count_2", 72'(pad_count), 72'(2));
        idle(1);

        // Backpressure
        ms_ready = 1'b0;
        for (int b = 0; b < 9; b++) send(8'h11 + 8'(b), 1'b0, 1'b0, cyc);
        d0 = ms_data;
        check("bp_data", d0, 72'h191817161514131211);
        ss_valid = 1'b1; ss_data = 8'h21; ss_last = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            check("bp_ss_ready", 72'(ss_ready), 72'(0));
            check("bp_hold", ms_data, d0);
        end
        ms_ready = 1'b1;
        tick();
        check("bp_refill_same_edge", 72'(last_acc), 72'(1));
        check("bp_word_count", 72'(word_count), 72'(4));
        for (int b = 2; b <= 9; b++) send(8'h20 + 8'(b), 1'b0, 1'b0, cyc);
        idle(2);

        // Streaming without bubbles
        w0 = m_words;
        for (int i = 0; i < 900; i++) begin
            send(8'(i), 1'b0, 1'b0, cyc);
            check("stream_no_bubble", 72'(cyc), 72'(1));
        end
        idle(2);
        check("stream_words", 72'(word_count), 72'(w0 + 32'd100));

        // Random handshake
        for (int i = 0; i < 2000; i++)
            send(8'($urandom_range(0, 255)), ($urandom_range(0, 6) == 0), 1'b1, cyc);
        ss_valid = 1'b0; ms_ready = 1'b1;
        idle(3);
        check("rand_word_count", 72'(word_count), 72'(m_words));
        check("rand_pad_count", 72'(pad_count), 72'(m_pads));
        check("rand_sb_drained", 72'(sb_q.size()), 72'(0));

        // Reset with a word pending
        ms_ready = 1'b0;
        for (int b = 0; b < 9; b++) send(8'h31 + 8'(b), 1'b0, 1'b0, cyc);
        ss_valid = 1'b0;
        check("rstp_pending", 72'(ms_valid), 72'(1));
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        check("rstp_ms_valid", 72'(ms_valid), 72'(0));
        check("rstp_word_count", 72'(word_count), 72'(0));
        check("rstp_pad_count", 72'(pad_count), 72'(0));

        // Reset mid-word discards the partial accumulator
        ms_ready = 1'b1;
        for (int b = 0; b < 4; b++) send(8'h41 + 8'(b), 1'b0, 1'b0, cyc);
        ss_valid = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int b = 0; b < 9; b++) send(8'h51 + 8'(b), 1'b0, 1'b0, cyc);
        ss_valid = 1'b0;
        check("rstm_data", ms_data, 72'h595857565554535251);
        tick();
        check("rstm_word_count", 72'(word_count), 72'(1));
        check("rstm_pad_count", 72'(pad_count), 72'(0));
        idle(2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/byte_word_packer.md
# byte_word_packer

Upstream stage of `bram_fifo`: packs an 8-bit byte stream into the 72-bit words the FIFO buffers for the accelerator. Nine bytes make one word, first byte in the least-significant lane. A word left incomplete when `ss_last` arrives is zero-padded and flushed. Both sides use the `ss_*` / `ms_*` valid/ready handshake, and `ms_*` connects directly to the FIFO's `ss_*` port.

## Interface
- `BYTE_W`, 8: input lane width.
- `LANES`, 9: bytes per output word; output width is `BYTE_W*LANES` = 72.
- `CNT_W`, 32: width of the status counters.

Ports:
- `clk`  in  1  : single clock, rising edge.
- `reset`  in  1  : synchronous, active-high.
- `ss_data`  in  8  : input byte.
- `ss_valid`  in  1  : input byte valid.
- `ss_ready`  out  1  : block accepts the byte on `ss_data`.
- `ss_last`  in  1  : byte ends a packet; sampled only on an accepted beat.
- `ms_data`  out  72  : packed word.
- `ms_valid`  out  1  : `ms_data` valid.
- `ms_ready`  in  1  : downstream FIFO accepts the word.
- `word_count`  out  `CNT_W`  : number of words emitted (`ms` handshakes).
- `pad_count`  out  `CNT_W`  : number of words emitted with zero padding.

## Operation
- Internal state:
  - `acc`: accumulator, 72 bits.
  - `idx`: lane index, 0..`LANES-1`.
  - Output register: `ms_data` / `ms_valid`.
- Byte accepted when `ss_valid && ss_ready`. The byte is written to lane `idx` (bits `[idx*8 +: 8]`).
- Word completes on an accepted byte when `idx == LANES-1` or `ss_last == 1`. On the same edge:
  - Word = `acc` with the new byte merged in; lanes above `idx` are forced to 0.
  - Word is loaded into the output register and `ms_valid` is set.
  - `acc` is cleared and `idx` returns to 0.
  - `pad_count` increments when the word is completed by `ss_last` with `idx < LANES-1`. It increments at load time, not at the `ms` handshake.
- Otherwise, an accepted byte increments `idx`.
- `ss_ready = !reset && (!ms_valid || ms_ready)`.
  - This is the only ready rule. It does not depend on `ss_valid` or `ss_last`, so there is no combinational path from valid to ready.
- `ms_valid` clears on `ms_valid && ms_ready` unless a new word loads on the same edge. A simultaneous drain and load keeps `ms_valid` at 1 and updates `ms_data`.
- `word_count` increments on each `ms_valid && ms_ready`.
- Both counters wrap modulo 2^`CNT_W`.
- Empty packet cannot occur: `ss_last` always arrives with a byte. `ss_last` at lane 8 gives an unpadded word, and `pad_count` does not change.

## Timing
- Reset values: `ms_valid` = 0, `ms_data` = 0, `ss_ready` = 0 while `reset` = 1, `acc` = 0, `idx` = 0, `word_count` = 0, `pad_count` = 0.
- Reset mid-word discards the partial `acc`. Reset with `ms_valid` = 1 drops the pending word, and `word_count` does not count it.
- Latency: a word appears on `ms_data` with `ms_valid` = 1 one cycle after the edge that accepted its final byte.
- Throughput: 1 byte per cycle with no bubbles while `ms_ready` stays high. A word leaves every 9 cycles.
- Stall: while `ms_valid && !ms_ready`, `ss_ready` = 0 and `ms_data` is held stable. No bytes are accepted in this state, including non-completing bytes.
- Drain and refill on the same edge are allowed, so there is no dead cycle between consecutive words.

## Structure
- Shared wrapper package holds:
  - `BYTE_W`, `LANES`, `STREAM_W` (= 72).
  - The lane-ordering constant (LSB-first), which is also used by the accelerator-side unpacker.
- Sub-module: `byte_lane_merge`, a combinational block that takes `acc`, `idx`, the byte and a pad flag and produces the merged/masked word. Single instance.
- All sequential logic (index, output register, counters) stays in the top module.

## Test plan
- Basic pack: after reset, feed bytes 0x01..0x09 with `ms_ready` = 1 → one word `0x090807060504030201` appears the cycle after byte 0x09; `word_count` = 1, `pad_count` = 0.
- Padding: feed 0xA1, 0xA2, 0xA3 with `ss_last` on 0xA3 → `ms_data` = `0x000000000000A3A2A1`; `pad_count` = 1; the next byte lands in lane 0.
- Backpressure: fill one word with `ms_ready` = 0 → `ss_ready` = 0 and `ms_data` stable for 20 cycles; raise `ms_ready` → word accepted and the next byte accepted on the same edge.
- Streaming: 900 incrementing bytes with `ms_ready` = 1 → 100 words, no idle cycle on `ss_ready`, data matches a scoreboard.
- Random handshake: `ss_valid` and `ms_ready` each random 50%, 2000 bytes with random `ss_last`, `bram_fifo` attached downstream → FIFO output matches the reference packing model exactly; counters match the model.
- Reset mid-word: reset asserted after 4 bytes while a word is pending → `ms_valid` = 0; first word after reset contains only post-reset bytes; counters = 0.
